// File: rtl/float_norm_pkg.sv
// Shared widths, result layout and the exponent/shift clamp for the normalize scheduler.
package float_norm_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MANT_WIDTH  = 26;
    localparam int DEF_SHIFT_WIDTH = 5;
    localparam int DEF_EXP_WIDTH   = 8;
    localparam int DEF_ID_WIDTH    = 2;
    localparam int ADJ_WIDTH       = 16;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_MANT_WIDTH-1:0] mant;
        logic [DEF_EXP_WIDTH-1:0]  exp;
        logic                      zero;
        logic                      uflow;
    } norm_res_t;

    typedef struct packed {
        logic [ADJ_WIDTH-1:0] shift;
        logic [ADJ_WIDTH-1:0] exp;
        logic                 uflow;
    } norm_adj_t;

    // Borrow out of the one-bit-wider subtraction means the shift would push the exponent below 0.
    function automatic norm_adj_t norm_adjust(input logic [ADJ_WIDTH-1:0] lz,
                                              input logic [ADJ_WIDTH-1:0] exp);
        norm_adj_t          r;
        logic [ADJ_WIDTH:0] diff;
        diff = {1'b0, exp} - {1'b0, lz};
        if (diff[ADJ_WIDTH]) begin
            r.shift = exp;
            r.exp   = '0;
            r.uflow = 1'b1;
        end else begin
            r.shift = lz;
            r.exp   = diff[ADJ_WIDTH-1:0];
            r.uflow = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/float_naive_lzc.sv
// Naive leading-zero counter; an all-zero input reports INPUT_WIDTH.
module float_naive_lzc #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 5,
    parameter int OUTPUT_STEP  = 1,
    parameter int OUTPUT_BIAS  = 0
) (
    input  logic [INPUT_WIDTH-1:0]  data_in,
    output logic [OUTPUT_WIDTH-1:0] count
);

    always_comb begin
        int n;
        n = INPUT_WIDTH;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            if (data_in[i]) n = INPUT_WIDTH - 1 - i;
        end
        count = OUTPUT_WIDTH'(n * OUTPUT_STEP + OUTPUT_BIAS);
    end

endmodule

// File: rtl/float_norm_rr_arb.sv
// Round-robin arbiter: searches from ptr upward and moves ptr past the lane that handshakes.
module float_norm_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               load_en,
    output logic [NUM_REQ-1:0] ready,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [IDX_W-1:0]   ptr
);

    logic found;

    always_comb begin
        int j;
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (found && load_en && !rst) ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|ready) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/float_norm_sched.sv
// Shares one LZC/normalize datapath among NUM_REQ lanes through a two-stage pipeline.
module float_norm_sched
    import float_norm_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MANT_WIDTH  = DEF_MANT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int EXP_WIDTH   = DEF_EXP_WIDTH,
    parameter int ID_WIDTH    = DEF_ID_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*MANT_WIDTH-1:0] req_mant,
    input  logic [NUM_REQ*EXP_WIDTH-1:0]  req_exp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic [MANT_WIDTH-1:0]         out_mant,
    output logic [EXP_WIDTH-1:0]          out_exp,
    output logic                          out_zero,
    output logic                          out_uflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a producer keeps
    // valid and data stable until then, and ready may depend combinationally on valid.
    logic                   s1_valid;
    logic [ID_WIDTH-1:0]    s1_id;
    logic [MANT_WIDTH-1:0]  s1_mant;
    logic [EXP_WIDTH-1:0]   s1_exp;
    logic                   s2_load;
    logic                   s1_load;
    logic                   accept;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       ptr;
    logic [SHIFT_WIDTH-1:0] lz;
    norm_adj_t              adj;

    assign s2_load = !out_valid || out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign accept  = |req_ready;

    float_norm_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .load_en   (s1_load),
        .ready     (req_ready),
        .grant_idx (grant_idx),
        .ptr       (ptr)
    );

    float_naive_lzc #(
        .INPUT_WIDTH  (MANT_WIDTH),
        .OUTPUT_WIDTH (SHIFT_WIDTH),
        .OUTPUT_STEP  (1),
        .OUTPUT_BIAS  (0)
    ) u_lzc (
        .data_in (s1_mant),
        .count   (lz)
    );

    assign adj = norm_adjust(ADJ_WIDTH'(lz), ADJ_WIDTH'(s1_exp));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_mant   <= '0;
            s1_exp    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_id   <= ID_WIDTH'(grant_idx);
                    s1_mant <= req_mant[grant_idx*MANT_WIDTH +: MANT_WIDTH];
                    s1_exp  <= req_exp[grant_idx*EXP_WIDTH +: EXP_WIDTH];
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_id <= s1_id;
                    if (s1_mant == '0) begin
                        out_mant  <= '0;
                        out_exp   <= '0;
                        out_zero  <= 1'b1;
                        out_uflow <= 1'b0;
                    end else begin
                        out_mant  <= s1_mant << adj.shift[SHIFT_WIDTH-1:0];
                        out_exp   <= adj.exp[EXP_WIDTH-1:0];
                        out_zero  <= 1'b0;
                        out_uflow <= adj.uflow;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_float_norm_sched.sv
// Directed and random stimulus for float_norm_sched with a reference model and result queue.
module tb_float_norm_sched;
    import float_norm_pkg::*;

    localparam int NR    = 4;
    localparam int MW    = 26;
    localparam int EW    = 8;
    localparam int IW    = 2;
    localparam int RES_W = $bits(norm_res_t);

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*MW-1:0]   req_mant;
    logic [NR*EW-1:0]   req_exp;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      out_id;
    logic [MW-1:0]      out_mant;
    logic [EW-1:0]      out_exp;
    logic               out_zero;
    logic               out_uflow;

    float_norm_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mant  (req_mant),
        .req_exp   (req_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lane stimulus state and reference model state
    logic [NR-1:0] lane_v;
    logic [MW-1:0] lane_m [NR];
    logic [EW-1:0] lane_e [NR];
    bit            hold;
    int            m_ptr;
    bit            m_s1v;
    bit            m_s2v;
    bit            m_outs_zero;
    logic [RES_W-1:0] exp_q[$];
    int            vectors;
    int            errors;

    function automatic logic [RES_W-1:0] model(input int id, input logic [MW-1:0] m,
                                               input logic [EW-1:0] e);
        norm_res_t r;
        int n;
        r = '0;
        r.id = IW'(id);
        if (m == '0) begin
            r.zero = 1'b1;
        end else begin
            n = 0;
            while (!m[MW-1-n]) n++;
            if (n <= int'(e)) begin
                r.mant = m << n;
                r.exp  = EW'(int'(e) - n);
            end else begin
                r.mant  = m << e;
                r.exp   = '0;
                r.uflow = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic new_data(input int i);
        lane_m[i] = MW'($urandom >> $urandom_range(6, 31));
        lane_e[i] = EW'($urandom_range(0, 40));
    endtask

    // one cycle: drive, check mid-cycle, advance the model, move past the next rising edge
    task automatic step();
        logic [NR-1:0]    exp_ready;
        logic [RES_W-1:0] obs;
        bit               can_load;
        bit               s2_load;
        bit               n_s1v;
        bit               n_s2v;
        int               g;
        int               j;
        for (int i = 0; i < NR; i++) begin
            req_mant[i*MW +: MW] = lane_m[i];
            req_exp[i*EW +: EW]  = lane_e[i];
        end
        req_valid = lane_v;
        #3;
        can_load  = !m_s1v || !m_s2v || out_ready;
        exp_ready = '0;
        g = -1;
        if (!rst && can_load) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (g < 0 && lane_v[j]) g = j;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        obs = {out_id, out_mant, out_exp, out_zero, out_uflow};

        vectors++;
        assert (req_ready === exp_ready) else begin
            errors++;
            $error("FAIL req_ready observed=%b expected=%b", req_ready, exp_ready);
        end
        vectors++;
        assert (out_valid === m_s2v) else begin
            errors++;
            $error("FAIL out_valid observed=%b expected=%b", out_valid, m_s2v);
        end
        if (m_s2v) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result observed=%h expected=<empty queue>", obs);
            end else begin
                assert (obs === exp_q[0]) else begin
                    errors++;
                    $error("FAIL result observed=%h expected=%h", obs, exp_q[0]);
                end
            end
        end else if (m_outs_zero) begin
            vectors++;
            assert (obs === '0) else begin
                errors++;
                $error("FAIL reset_outs observed=%h expected=0", obs);
            end
        end

        if (rst) begin
            m_s1v = 0;
            m_s2v = 0;
            m_ptr = 0;
            m_outs_zero = 1;
            exp_q.delete();
        end else begin
            s2_load = !m_s2v || out_ready;
            n_s1v = m_s1v;
            n_s2v = m_s2v;
            if (m_s2v && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s2_load) begin
                n_s2v = m_s1v;
                if (m_s1v) m_outs_zero = 0;
            end
            if (can_load) n_s1v = (g >= 0);
            if (g >= 0) begin
                exp_q.push_back(model(g, lane_m[g], lane_e[g]));
                m_ptr = (g + 1) % NR;
                if (hold) new_data(g);
                else lane_v[g] = 1'b0;
            end
            m_s1v = n_s1v;
            m_s2v = n_s2v;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [MW-1:0] m, input logic [EW-1:0] e);
        lane_v[i] = 1'b1;
        lane_m[i] = m;
        lane_e[i] = e;
    endtask

    task automatic drain();
        int budget;
        out_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || m_s1v || m_s2v || lane_v != '0) && budget < 40) begin
            step();
            budget++;
        end
        vectors++;
        assert (exp_q.size() == 0 && budget < 40) else begin
            errors++;
            $error("FAIL drain observed=%0d left expected=0 (budget %0d)", exp_q.size(), budget);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        hold    = 0;
        lane_v  = '0;
        for (int i = 0; i < NR; i++) begin
            lane_m[i] = '0;
            lane_e[i] = '0;
        end
        req_valid = '0;
        req_mant  = '0;
        req_exp   = '0;
        out_ready = 1'b1;
        m_ptr = 0;
        m_s1v = 0;
        m_s2v = 0;
        m_outs_zero = 1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();

        // single request, zero mantissa, underflow clamp, exact-boundary exponent
        set_lane(2, 26'h0100000, 8'd100);
        repeat (4) step();
        set_lane(0, 26'h0000000, 8'd50);
        repeat (4) step();
        set_lane(1, 26'h0000001, 8'd3);
        repeat (4) step();
        set_lane(3, 26'h0000001, 8'd25);
        repeat (4) step();

        // fairness from a fresh reset: all lanes requesting for 8 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold = 1;
        for (int i = 0; i < NR; i++) begin
            lane_v[i] = 1'b1;
            new_data(i);
        end
        repeat (8) step();
        hold = 0;
        lane_v = '0;
        drain();

        // backpressure with lanes 1 and 3 requesting
        hold = 1;
        set_lane(1, 26'h0003abc, 8'd30);
        set_lane(3, 26'h1000000, 8'd7);
        out_ready = 1'b0;
        repeat (5) step();
        hold = 0;
        drain();

        // reset with both stages full, then lanes 1 and 2 compete
        hold = 1;
        for (int i = 0; i < NR; i++) begin
            lane_v[i] = 1'b1;
            new_data(i);
        end
        out_ready = 1'b0;
        repeat (3) step();
        hold = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        lane_v = '0;
        set_lane(2, 26'h0000400, 8'd12);
        set_lane(1, 26'h0000000, 8'd9);
        out_ready = 1'b1;
        drain();

        // random traffic with random backpressure
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!lane_v[i] && $urandom_range(0, 2) == 0) begin
                    lane_v[i] = 1'b1;
                    new_data(i);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
